// File: rtl/stream_cipher_core.sv
// Byte-serial Galois-LFSR stream cipher: XORs each byte with 8 keystream bits.
// Ports: clk, nrst, key_in/key_load, data_in/data_valid, busy, overrun, data_out/data_out_pulse.
module stream_cipher_core #(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [LFSR_W-1:0] key_in,
  input  logic              key_load,
  input  logic [7:0]        data_in,
  input  logic              data_valid,
  output logic              busy,
  output logic              overrun,
  output logic [7:0]        data_out,
  output logic              data_out_pulse
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    EMIT
  } state_t;

  state_t            state;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_next;
  logic [LFSR_W-1:0] key_eff;
  logic [7:0]        byte_reg;
  logic [7:0]        ks_reg;
  logic [2:0]        bit_cnt;

  assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);

  // An all-zero state would lock the LFSR, so fall back to SEED.
  assign key_eff = (key_in == '0) ? SEED : key_in;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state          <= IDLE;
      lfsr           <= SEED;
      byte_reg       <= '0;
      ks_reg         <= '0;
      bit_cnt        <= '0;
      overrun        <= 1'b0;
      data_out       <= '0;
      data_out_pulse <= 1'b0;
    end else begin
      data_out_pulse <= 1'b0;
      if (key_load) begin
        lfsr    <= key_eff;
        ks_reg  <= '0;
        bit_cnt <= '0;
        state   <= IDLE;
        overrun <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (data_valid) begin
              byte_reg <= data_in;
              bit_cnt  <= '0;
              state    <= SHIFT;
            end
          end
          SHIFT: begin
            if (data_valid) overrun <= 1'b1;
            lfsr            <= lfsr_next;
            ks_reg[bit_cnt] <= lfsr[0];
            bit_cnt         <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= EMIT;
          end
          EMIT: begin
            if (data_valid) overrun <= 1'b1;
            data_out       <= byte_reg ^ ks_reg;
            data_out_pulse <= 1'b1;
            state          <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stream_cipher_core.sv
// Testbench for stream_cipher_core: scoreboard of expected bytes,
// latency/busy/overrun checks, key abort and async reset scenarios.
module tb_stream_cipher_core;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] TAPS = 16'hB400;

  logic        clk;
  logic        nrst;
  logic [15:0] key_in;
  logic        key_load;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        busy;
  logic        overrun;
  logic [7:0]  data_out;
  logic        data_out_pulse;

  stream_cipher_core dut (
    .clk            (clk),
    .nrst           (nrst),
    .key_in         (key_in),
    .key_load       (key_load),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .busy           (busy),
    .overrun        (overrun),
    .data_out       (data_out),
    .data_out_pulse (data_out_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp;
  int          n_fail;
  int          n_pulse;
  logic [15:0] m_lfsr;
  logic [7:0]  exp_q[$];
  logic [7:0]  seed_byte;

  always @(negedge clk) begin
    if (data_out_pulse) n_pulse++;
  end

  task automatic model_ks(output logic [7:0] k);
    for (int i = 0; i < 8; i++) begin
      k[i]   = m_lfsr[0];
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? TAPS : 16'h0000);
    end
  endtask

  task automatic load_key(input logic [15:0] k);
    key_in   = k;
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    m_lfsr   = (k == 16'h0000) ? SEED : k;
  endtask

  // Drives one byte from a negedge and returns at the negedge where the
  // pulse is seen (or after a bounded wait).
  task automatic run_byte(input logic [7:0] d, input logic [7:0] e,
                          output int lat, output int bc);
    exp_q.push_back(e);
    data_in    = d;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    lat = 0;
    bc  = busy ? 1 : 0;
    while (!data_out_pulse && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
    end
  endtask

  task automatic test_reset;
    nrst       = 1'b0;
    key_in     = '0;
    key_load   = 1'b0;
    data_in    = '0;
    data_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got=%b want=0", busy);
    end
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_overrun: got=%b want=0", overrun);
    end
    n_cmp++;
    if (data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data_out: got=%h want=00", data_out);
    end
    n_cmp++;
    if (data_out_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pulse: got=%b want=0", data_out_pulse);
    end
    nrst   = 1'b1;
    m_lfsr = SEED;
    @(negedge clk);
  endtask

  task automatic test_seed;
    int         lat;
    int         bc;
    logic [7:0] k;
    logic [7:0] e;
    model_ks(k);
    seed_byte = k;
    run_byte(8'h00, k, lat, bc);
    e = exp_q.pop_front();
    n_cmp++;
    if (data_out !== e) begin
      n_fail++;
      $display("FAIL seed_byte: got=%h want=%h", data_out, e);
    end
  endtask

  task automatic test_known;
    int         lat;
    int         bc;
    logic [7:0] k;
    logic [7:0] e;
    load_key(16'h0001);
    model_ks(k);
    run_byte(8'h00, 8'h01, lat, bc);
    n_cmp++;
    if (lat != 9) begin
      n_fail++;
      $display("FAIL known_lat0: got=%0d want=9", lat);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (data_out !== e) begin
      n_fail++;
      $display("FAIL known_b0: got=%h want=%h", data_out, e);
    end
    @(negedge clk);
    n_cmp++;
    if (data_out_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse_width: got=%b want=0", data_out_pulse);
    end
    model_ks(k);
    run_byte(8'h00, 8'h68, lat, bc);
    n_cmp++;
    if (bc != 9) begin
      n_fail++;
      $display("FAIL known_busy: got=%0d want=9", bc);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (data_out !== e) begin
      n_fail++;
      $display("FAIL known_b1: got=%h want=%h", data_out, e);
    end
    n_cmp++;
    if (m_lfsr !== 16'h7C41 || k !== 8'h68) begin
      n_fail++;
      $display("FAIL model_lfsr: got=%h/%h want=7c41/68", m_lfsr, k);
    end
  endtask

  task automatic test_round_trip;
    int         lat;
    int         bc;
    logic [7:0] k;
    logic [7:0] e;
    load_key(16'h0001);
    model_ks(k);
    run_byte(8'h5A, 8'h5B, lat, bc);
    e = exp_q.pop_front();
    n_cmp++;
    if (data_out !== e) begin
      n_fail++;
      $display("FAIL rt_enc: got=%h want=%h", data_out, e);
    end
    load_key(16'h0001);
    model_ks(k);
    run_byte(8'h5B, 8'h5A, lat, bc);
    e = exp_q.pop_front();
    n_cmp++;
    if (data_out !== e) begin
      n_fail++;
      $display("FAIL rt_dec: got=%h want=%h", data_out, e);
    end
  endtask

  task automatic test_zero_key;
    int         lat;
    int         bc;
    logic [7:0] k;
    logic [7:0] e;
    load_key(16'h0000);
    model_ks(k);
    run_byte(8'h00, seed_byte, lat, bc);
    e = exp_q.pop_front();
    n_cmp++;
    if (data_out !== e) begin
      n_fail++;
      $display("FAIL zero_key: got=%h want=%h", data_out, e);
    end
    model_ks(k);
    run_byte(8'h00, k, lat, bc);
    e = exp_q.pop_front();
    n_cmp++;
    if (data_out !== e) begin
      n_fail++;
      $display("FAIL zero_key_b1: got=%h want=%h", data_out, e);
    end
  endtask

  task automatic test_overrun;
    int         lat;
    logic [7:0] k;
    logic [7:0] e;
    load_key(16'hBEEF);
    model_ks(k);
    exp_q.push_back(8'hC3 ^ k);
    data_in    = 8'hC3;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (2) @(negedge clk);
    data_in    = 8'hFF;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: got=%b want=1", overrun);
    end
    lat = 3;
    while (!data_out_pulse && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat != 9) begin
      n_fail++;
      $display("FAIL overrun_lat: got=%0d want=9", lat);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (data_out !== e) begin
      n_fail++;
      $display("FAIL overrun_data: got=%h want=%h", data_out, e);
    end
    @(negedge clk);
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_sticky: got=%b want=1", overrun);
    end
    load_key(16'h0001);
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear: got=%b want=0", overrun);
    end
  endtask

  task automatic test_key_abort;
    int         lat;
    int         bc;
    int         p0;
    logic [7:0] e;
    data_in    = 8'h77;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (3) @(negedge clk);
    key_in     = 16'h0001;
    key_load   = 1'b1;
    data_valid = 1'b1;
    p0 = n_pulse;
    @(negedge clk);
    key_load   = 1'b0;
    data_valid = 1'b0;
    m_lfsr     = 16'h0001;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_busy: got=%b want=0", busy);
    end
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_overrun: got=%b want=0", overrun);
    end
    repeat (12) @(negedge clk);
    n_cmp++;
    if (n_pulse != p0) begin
      n_fail++;
      $display("FAIL abort_pulse: got=%0d want=%0d", n_pulse, p0);
    end
    run_byte(8'h00, 8'h01, lat, bc);
    e = exp_q.pop_front();
    n_cmp++;
    if (data_out !== e) begin
      n_fail++;
      $display("FAIL abort_restart: got=%h want=%h", data_out, e);
    end
  endtask

  task automatic test_reset_mid_shift;
    int         lat;
    int         bc;
    logic [7:0] k;
    logic [7:0] e;
    data_in    = 8'h3C;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    @(negedge clk);
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_flags: got=%b%b want=00", busy, overrun);
    end
    n_cmp++;
    if (data_out !== 8'h00 || data_out_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_out: got=%h/%b want=00/0", data_out, data_out_pulse);
    end
    @(negedge clk);
    nrst   = 1'b1;
    m_lfsr = SEED;
    @(negedge clk);
    model_ks(k);
    run_byte(8'h00, seed_byte, lat, bc);
    e = exp_q.pop_front();
    n_cmp++;
    if (data_out !== e || k !== seed_byte) begin
      n_fail++;
      $display("FAIL rst_mid_seed: got=%h want=%h", data_out, e);
    end
  endtask

  task automatic test_back_to_back;
    int         lat;
    int         bc;
    logic [7:0] d;
    logic [7:0] k;
    logic [7:0] e;
    load_key(16'h1234);
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 255));
      model_ks(k);
      run_byte(d, d ^ k, lat, bc);
      n_cmp++;
      if (lat != 9) begin
        n_fail++;
        $display("FAIL b2b_lat%0d: got=%0d want=9", i, lat);
      end
      e = exp_q.pop_front();
      n_cmp++;
      if (data_out !== e) begin
        n_fail++;
        $display("FAIL b2b_data%0d: got=%h want=%h", i, data_out, e);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_overrun: got=%b want=0", overrun);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    n_pulse = 0;
    test_reset;
    test_seed;
    test_known;
    test_round_trip;
    test_zero_key;
    test_overrun;
    test_key_abort;
    test_reset_mid_shift;
    test_back_to_back;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_left: got=%0d want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
